// File: rtl/axis_to_video_out_pkg.sv
// Shared definitions for the AXI4-Stream to video output path: default raster
// geometry, derived-constant helpers and the stream-lock FSM encoding.
package axis_to_video_out_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 40;
    localparam int unsigned DEF_H_ACTIVE   = 480;
    localparam int unsigned DEF_H_FP       = 20;
    localparam int unsigned DEF_H_SYNC     = 10;
    localparam int unsigned DEF_H_BP       = 20;
    localparam int unsigned DEF_V_ACTIVE   = 1080;
    localparam int unsigned DEF_V_FP       = 4;
    localparam int unsigned DEF_V_SYNC     = 5;
    localparam int unsigned DEF_V_BP       = 36;

    localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Stream lock state: discard/hold until SOF lines up with raster origin, then run.
    typedef enum logic {
        WAIT_SOF = 1'b0,
        RUN      = 1'b1
    } state_e;

    // Total period of one raster axis (active + front porch + sync + back porch).
    function automatic int unsigned span_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // First counter value with sync asserted.
    function automatic int unsigned sync_start(input int unsigned active, input int unsigned fp);
        return active + fp;
    endfunction

    // First counter value after sync deasserts.
    function automatic int unsigned sync_end(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync);
        return active + fp + sync;
    endfunction

    // Counter width able to hold 0..total-1.
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total <= 1) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster generator: horizontal/vertical position counters plus
// active-area and sync decode of the current position.
// Ports:
//   I_clk, I_rst_n  clock, synchronous active-low reset (counters to 0,0)
//   O_h_cnt         horizontal position, registered
//   O_v_cnt         vertical position, registered
//   O_active_c      current position is inside the active area
//   O_hs_c / O_vs_c current position is inside horizontal / vertical sync (active high)
module video_timing_gen
    import axis_to_video_out_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned H_CNT_W = cnt_width(H_TOTAL),
    localparam int unsigned V_CNT_W = cnt_width(V_TOTAL)
)
(
    input  logic               I_clk,
    input  logic               I_rst_n,
    output logic [H_CNT_W-1:0] O_h_cnt,
    output logic [V_CNT_W-1:0] O_v_cnt,
    output logic               O_active_c,
    output logic               O_hs_c,
    output logic               O_vs_c
);

    localparam int unsigned HS_START = sync_start(H_ACTIVE, H_FP);
    localparam int unsigned HS_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
    localparam int unsigned VS_START = sync_start(V_ACTIVE, V_FP);
    localparam int unsigned VS_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);

    // Position counters; never stall, vertical advances on horizontal wrap.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            O_h_cnt <= '0;
            O_v_cnt <= '0;
        end else if (O_h_cnt == H_CNT_W'(H_TOTAL - 1)) begin
            O_h_cnt <= '0;
            O_v_cnt <= (O_v_cnt == V_CNT_W'(V_TOTAL - 1)) ? '0 : O_v_cnt + 1'b1;
        end else begin
            O_h_cnt <= O_h_cnt + 1'b1;
        end
    end

    // Decode in 32 bits so boundary constants equal to the total never truncate.
    assign O_active_c = (32'(O_h_cnt) < H_ACTIVE) && (32'(O_v_cnt) < V_ACTIVE);
    assign O_hs_c     = (32'(O_h_cnt) >= HS_START) && (32'(O_h_cnt) < HS_END);
    assign O_vs_c     = (32'(O_v_cnt) >= VS_START) && (32'(O_v_cnt) < VS_END);

endmodule

// File: rtl/axis_to_video_out.sv
// Sink end of the camera stream: pulls RAW10 beats only during active pixels of a
// free-running raster and drives registered de/hs/vs/data toward the HDMI side.
// Locks on SOF at raster origin and falls back to searching after any mismatch.
// Ports:
//   I_clk, I_rst_n        clock, synchronous active-low reset
//   I_axis_tdata/tvalid   stream beat
//   I_axis_tuser          start of frame (first beat of line 0)
//   I_axis_tlast          end of line (beat H_ACTIVE-1)
//   O_axis_tready         stream ready, combinational from state + raster position
//   O_de, O_hs, O_vs      registered timing, syncs at SYNC_POL when asserted
//   O_data                registered pixel data, 0 unless a good beat was consumed
//   O_err_underflow       pulse: active pixel with no beat available while running
//   O_err_sync            pulse: tuser/tlast at the wrong raster position while running
module axis_to_video_out
    import axis_to_video_out_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter bit          SYNC_POL   = 1'b1
)
(
    input  logic                  I_clk,
    input  logic                  I_rst_n,
    input  logic [DATA_WIDTH-1:0] I_axis_tdata,
    input  logic                  I_axis_tvalid,
    input  logic                  I_axis_tuser,
    input  logic                  I_axis_tlast,
    output logic                  O_axis_tready,
    output logic                  O_de,
    output logic                  O_hs,
    output logic                  O_vs,
    output logic [DATA_WIDTH-1:0] O_data,
    output logic                  O_err_underflow,
    output logic                  O_err_sync
);

    localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned H_CNT_W = cnt_width(H_TOTAL);
    localparam int unsigned V_CNT_W = cnt_width(V_TOTAL);

    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;
    logic               active_c;
    logic               hs_c;
    logic               vs_c;

    state_e state;

    logic at_sof_c;
    logic eol_c;
    logic tready_c;
    logic sof_lock_c;
    logic beat_ok_c;
    logic err_uf_c;
    logic err_sync_c;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .I_clk      (I_clk),
        .I_rst_n    (I_rst_n),
        .O_h_cnt    (h_cnt),
        .O_v_cnt    (v_cnt),
        .O_active_c (active_c),
        .O_hs_c     (hs_c),
        .O_vs_c     (vs_c)
    );

    // Per-position stream decisions: ready, beat acceptance and error detection.
    always_comb begin
        tready_c   = 1'b0;
        sof_lock_c = 1'b0;
        beat_ok_c  = 1'b0;
        err_uf_c   = 1'b0;
        err_sync_c = 1'b0;
        at_sof_c   = active_c && (h_cnt == '0) && (v_cnt == '0);
        eol_c      = (32'(h_cnt) == H_ACTIVE - 1);

        case (state)
            WAIT_SOF: begin
                // Drain non-SOF beats freely; hold an SOF beat until the raster origin.
                tready_c   = !I_axis_tuser || at_sof_c;
                sof_lock_c = I_axis_tvalid && I_axis_tuser && at_sof_c;
                // The locking beat is pixel 0 of the frame, so it is displayed.
                beat_ok_c  = sof_lock_c;
            end
            RUN: begin
                tready_c = active_c;
                if (active_c) begin
                    if (!I_axis_tvalid) begin
                        err_uf_c = 1'b1;
                    end else if (I_axis_tuser && !at_sof_c) begin
                        // A misplaced SOF is left in the stream to relock on.
                        tready_c   = 1'b0;
                        err_sync_c = 1'b1;
                    end else if ((I_axis_tlast != eol_c) || (at_sof_c && !I_axis_tuser)) begin
                        err_sync_c = 1'b1;
                    end else begin
                        beat_ok_c = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign O_axis_tready = I_rst_n && tready_c;

    // Lock FSM and registered video outputs.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state           <= WAIT_SOF;
            O_de            <= 1'b0;
            O_hs            <= ~SYNC_POL;
            O_vs            <= ~SYNC_POL;
            O_data          <= '0;
            O_err_underflow <= 1'b0;
            O_err_sync      <= 1'b0;
        end else begin
            O_de            <= active_c;
            O_hs            <= hs_c ? SYNC_POL : ~SYNC_POL;
            O_vs            <= vs_c ? SYNC_POL : ~SYNC_POL;
            O_data          <= beat_ok_c ? I_axis_tdata : '0;
            O_err_underflow <= err_uf_c;
            O_err_sync      <= err_sync_c;
            case (state)
                WAIT_SOF: if (sof_lock_c) state <= RUN;
                RUN:      if (err_uf_c || err_sync_c) state <= WAIT_SOF;
                default:  state <= WAIT_SOF;
            endcase
        end
    end

endmodule
